poly_note_player: RTL and testbench
===================================

Name: poly_note_player

Overview:
Parametrised multi-voice successor to the single-voice note player. Holds up to NUM_VOICES concurrent notes. Each note has its own beat-counted duration and phase accumulator. On each sample request the block mixes all active voices into one signed sample. It sits between the song reader / chord sequencer (note loads) and the codec frame logic (sample requests).

Parameters:
NUM_VOICES, 4, concurrent voices; power of two, 2..8
NOTE_W, 6, note number width; 0 = rest, 1..63 = key number, 49 = A4 (440 Hz)
DUR_W, 6, duration width in beats
SAMPLE_W, 16, signed output sample width
PHASE_W, 20, phase accumulator width
SAMPLE_RATE, 48000, Hz; used only to build the step table

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_enable  in  1  1 = voices advance; 0 = paused
note_to_load  in  NOTE_W  note for a new voice
duration_to_load  in  DUR_W  duration in beats; 0 = load ignored
load_new_note  in  1  load request, sampled each cycle
load_ready  out  1  1 = at least one voice is free
wave_sel  in  2  waveform: 00 square, 01 sawtooth, 10/11 silent
beat  in  1  one-cycle beat strobe
generate_next_sample  in  1  one-cycle sample request
sample_out  out  SAMPLE_W  mixed signed sample; held between updates
new_sample_ready  out  1  one-cycle pulse when sample_out updates
voices_active  out  NUM_VOICES  per-voice occupied flags
done_with_note  out  1  one-cycle pulse when any voice expires

Behaviour:
- Reset (asynchronous, active-low): all outputs 0 except load_ready=1; all voices free; phases 0; FSM in IDLE.
- Load:
  - Accepted when load_new_note=1, load_ready=1 and duration_to_load!=0.
  - Allocates the lowest-index free voice; captures note and duration; sets the active flag next cycle.
  - When load_ready=0 or duration=0, the request is dropped silently.
  - A note of 0 (rest) occupies a voice and contributes 0.
- Duration:
  - When beat=1 and play_enable=1, every voice active before this cycle decrements its remaining count.
  - A voice loaded in the same cycle is not decremented.
  - On the 1->0 transition the voice is freed next cycle and its phase cleared; done_with_note pulses once for that cycle, even if several voices expire together.
- Pause: with play_enable=0, beats are ignored and phases frozen. Loads are still accepted.
- Sample FSM, states IDLE -> ACCUM -> OUT -> IDLE:
  - IDLE: generate_next_sample=1 clears the accumulator and enters ACCUM.
  - ACCUM: visits voice i=0..NUM_VOICES-1, one per cycle, adding that voice's contribution.
  - OUT: registers the result into sample_out and pulses new_sample_ready.
  - Latency: request cycle to new_sample_ready = NUM_VOICES+1 cycles.
  - Requests arriving in ACCUM or OUT are ignored.
- Voice contribution, evaluated at the visit with the current phase:
  - Square: +(2^(SAMPLE_W-1)-1) when phase MSB=0, else -2^(SAMPLE_W-1).
  - Sawtooth: phase[PHASE_W-1 -: SAMPLE_W], read as signed.
  - Contribution is 0 for inactive voices, rests, play_enable=0, or wave_sel of 10/11.
- Phase: after the visit, when the voice is active and play_enable=1, phase += STEP[note]. Wraps modulo 2^PHASE_W.
- Mix width:
  - The accumulator is SAMPLE_W+log2(NUM_VOICES) bits, signed.
  - sample_out = accumulator >>> log2(NUM_VOICES), arithmetic shift; no saturation is needed.
- A voice freed during ACCUM contributes according to its state at its own visit cycle.
- Loads, beats and sampling operate concurrently and are independent.

Decomposition:
- Package poly_note_pkg:
  - step_for_note(note) function / STEP table: round(2^PHASE_W * 440 * 2^((n-49)/12) / SAMPLE_RATE).
  - Waveform encoding constants.
  - FSM state enum.
  - clog2 helper.
- Sub-module np_voice holds one voice: note, remaining count, phase, active flag, contribution output. It is instantiated NUM_VOICES times.
- Top level holds the allocator priority encoder, the mixer FSM and the done_with_note OR-reduction.

Test Plan:
1. Reset low for 2 cycles -> sample_out=0, new_sample_ready=0, voices_active=0000, load_ready=1, done_with_note=0.
2. Load note 49, duration 2, then 2 beats with play_enable=1 -> voices_active=0001 after load; done_with_note pulses 1 cycle after the 2nd beat; voices_active returns to 0000.
3. Four loads (durations 3,3,3,3), then a fifth load -> voices_active=1111 and load_ready=0; the fifth load is dropped; after 3 beats all voices free together with a single done_with_note pulse.
4. One voice (note 49), square, first request -> new_sample_ready exactly 5 cycles later with sample_out=8191; subsequent samples alternate sign with a period of about 109 samples.
5. play_enable=0 with 2 active voices; beats plus a request -> sample_out=0, voices_active unchanged, no done_with_note; restoring play_enable resumes with the original remaining counts.
6. Simultaneous events: beat and load in the same cycle -> the new voice keeps its full duration. generate_next_sample during ACCUM -> no extra new_sample_ready. reset asserted mid-ACCUM -> immediate return to reset values.

Source files
------------

// File: rtl/poly_note_pkg.sv
// Shared definitions for the polyphonic note player: phase-step table builder,
// waveform codes, mixer FSM states and a ceil-log2 helper.
package poly_note_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } mix_state_t;

  // Only ever evaluated at elaboration to fill constant step tables.
  function automatic int step_for_note(input int note, input int phase_w, input int sample_rate);
    real freq_hz;
    if (note == 0) begin
      return 0;
    end else begin
      freq_hz = 440.0 * (2.0 ** ((note - 49) / 12.0));
      return $rtoi(freq_hz * (2.0 ** phase_w) / sample_rate + 0.5);
    end
  endfunction

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/np_voice.sv
// One voice of the polyphonic player: note, beat countdown, phase accumulator
// and the signed contribution it offers the mixer when visited.
module np_voice
  import poly_note_pkg::*;
#(
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int SAMPLE_W    = 16,
  parameter int PHASE_W     = 20,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       beat,
  input  logic [1:0]                 wave_sel,
  input  logic                       load_en,
  input  logic [NOTE_W-1:0]          load_note,
  input  logic [DUR_W-1:0]           load_dur,
  input  logic                       visit,
  output logic                       active,
  output logic                       active_nxt,
  output logic                       expire,
  output logic signed [SAMPLE_W-1:0] contrib
);

  localparam logic signed [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic                active_r;
  logic [NOTE_W-1:0]   note_r;
  logic [DUR_W-1:0]    remain_r;
  logic [PHASE_W-1:0]  phase_r;
  logic [PHASE_W-1:0]  step_tab_s [2**NOTE_W];
  logic                tick_s;

  for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_step
    localparam logic [PHASE_W-1:0] STEP_G = PHASE_W'(step_for_note(g, PHASE_W, SAMPLE_RATE));
    assign step_tab_s[g] = STEP_G;
  end

  assign tick_s     = beat & play_enable;
  assign expire     = active_r & tick_s & (remain_r == DUR_W'(1));
  assign active_nxt = load_en | (active_r & ~expire);
  assign active     = active_r;

  // Voice state: load a free voice, count beats down, advance phase on visits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_r <= 1'b0;
      note_r   <= '0;
      remain_r <= '0;
      phase_r  <= '0;
    end else if (load_en) begin
      active_r <= 1'b1;
      note_r   <= load_note;
      remain_r <= load_dur;
      phase_r  <= '0;
    end else if (active_r) begin
      if (expire) begin
        active_r <= 1'b0;
        remain_r <= '0;
        phase_r  <= '0;
      end else begin
        if (tick_s) begin
          remain_r <= remain_r - DUR_W'(1);
        end
        if (visit && play_enable) begin
          phase_r <= phase_r + step_tab_s[note_r];
        end
      end
    end
  end

  // Waveform value offered to the mixer; silent when idle, resting or paused.
  always_comb begin
    contrib = '0;
    if (active_r && (note_r != '0) && play_enable) begin
      case (wave_sel)
        WAVE_SQUARE: contrib = phase_r[PHASE_W-1] ? SQ_NEG : SQ_POS;
        WAVE_SAW:    contrib = phase_r[PHASE_W-1 -: SAMPLE_W];
        default:     contrib = '0;
      endcase
    end else begin
      contrib = '0;
    end
  end

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: allocates loads to the lowest free voice and mixes all
// voices into one signed sample, visiting one voice per cycle.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int SAMPLE_W    = 16,
  parameter int PHASE_W     = 20,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       load_new_note,
  output logic                       load_ready,
  input  logic [1:0]                 wave_sel,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready,
  output logic [NUM_VOICES-1:0]      voices_active,
  output logic                       done_with_note
);

  localparam int LOG_NV = clog2(NUM_VOICES);
  localparam int IDX_W  = (LOG_NV < 1) ? 1 : LOG_NV;
  localparam int ACC_W  = SAMPLE_W + LOG_NV;

  mix_state_t                  state_r;
  logic [IDX_W-1:0]            idx_r;
  logic signed [ACC_W-1:0]     acc_r;
  logic signed [ACC_W-1:0]     acc_nxt_s;
  logic signed [SAMPLE_W-1:0]  sample_r;
  logic                        ready_r;
  logic                        done_r;
  logic                        load_ready_r;

  logic [NUM_VOICES-1:0]       active_s;
  logic [NUM_VOICES-1:0]       active_nxt_s;
  logic [NUM_VOICES-1:0]       expire_s;
  logic [NUM_VOICES-1:0]       load_en_s;
  logic [NUM_VOICES-1:0]       visit_s;
  logic signed [SAMPLE_W-1:0]  contrib_s [NUM_VOICES];
  logic [IDX_W-1:0]            alloc_idx_s;
  logic                        load_accept_s;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    np_voice #(
      .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W),
      .PHASE_W(PHASE_W), .SAMPLE_RATE(SAMPLE_RATE)
    ) u_voice (
      .clk        (clk),
      .reset      (reset),
      .play_enable(play_enable),
      .beat       (beat),
      .wave_sel   (wave_sel),
      .load_en    (load_en_s[v]),
      .load_note  (note_to_load),
      .load_dur   (duration_to_load),
      .visit      (visit_s[v]),
      .active     (active_s[v]),
      .active_nxt (active_nxt_s[v]),
      .expire     (expire_s[v]),
      .contrib    (contrib_s[v])
    );
  end

  assign load_accept_s = load_new_note & load_ready_r & (duration_to_load != '0);

  // Lowest-index free voice wins; scanning downward lets lower indices overwrite.
  always_comb begin
    alloc_idx_s = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_s[i]) begin
        alloc_idx_s = IDX_W'(i);
      end else begin
        alloc_idx_s = alloc_idx_s;
      end
    end
  end

  // Per-voice load enable and mixer visit select.
  always_comb begin
    load_en_s = '0;
    visit_s   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      load_en_s[i] = load_accept_s && (alloc_idx_s == IDX_W'(i));
      visit_s[i]   = (state_r == ST_ACCUM) && (idx_r == IDX_W'(i));
    end
  end

  assign acc_nxt_s = acc_r + ACC_W'(contrib_s[idx_r]);

  // Mixer FSM: result is registered on the last visit so ready lands in OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      acc_r    <= '0;
      sample_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (generate_next_sample) begin
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_nxt_s;
          if (idx_r == IDX_W'(NUM_VOICES - 1)) begin
            sample_r <= SAMPLE_W'(acc_nxt_s >>> LOG_NV);
            ready_r  <= 1'b1;
            state_r  <= ST_OUT;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_OUT: begin
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Voice-level status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      done_r       <= |expire_s;
      load_ready_r <= ~&active_nxt_s;
    end
  end

  assign sample_out       = sample_r;
  assign new_sample_ready = ready_r;
  assign voices_active    = active_s;
  assign done_with_note   = done_r;
  assign load_ready       = load_ready_r;

endmodule

// File: tb/tb_poly_note_player.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a behavioural model of voices, beats and the sample mix.
module tb_poly_note_player;

  localparam int NV  = 4;
  localparam int PW  = 20;
  localparam int SW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              play_enable;
  logic [5:0]        note_to_load;
  logic [5:0]        duration_to_load;
  logic              load_new_note;
  logic              load_ready;
  logic [1:0]        wave_sel;
  logic              beat;
  logic              generate_next_sample;
  logic signed [15:0] sample_out;
  logic              new_sample_ready;
  logic [NV-1:0]     voices_active;
  logic              done_with_note;

  poly_note_player dut (
    .clk(clk), .reset(reset), .play_enable(play_enable),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_new_note(load_new_note), .load_ready(load_ready), .wave_sel(wave_sel),
    .beat(beat), .generate_next_sample(generate_next_sample),
    .sample_out(sample_out), .new_sample_ready(new_sample_ready),
    .voices_active(voices_active), .done_with_note(done_with_note)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit m_act [NV];
  int m_note [NV];
  int m_rem [NV];
  int m_phase [NV];
  int m_k;      // -1 idle, 0..NV-1 voice visited this cycle, -2 output cycle
  int m_acc;
  int e_sample, e_ready, e_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int step_model(input int n);
    if (n == 0) return 0;
    return int'((2.0 ** PW) * 440.0 * (2.0 ** ((n - 49) / 12.0)) / 48000.0);
  endfunction

  function automatic int contrib_model(input int v);
    int top;
    if (!m_act[v] || m_note[v] == 0 || !play_enable || wave_sel > 2'd1) return 0;
    if (wave_sel == 2'd0) return (m_phase[v] < (1 << (PW - 1))) ? 32767 : -32768;
    top = m_phase[v] >> (PW - SW);
    return (top >= 32768) ? top - 65536 : top;
  endfunction

  function automatic int floor_div(input int a, input int b);
    return (a - (((a % b) + b) % b)) / b;
  endfunction

  function automatic int active_vec();
    int v = 0;
    for (int i = 0; i < NV; i++) if (m_act[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_rem[i] = 0; m_phase[i] = 0;
    end
    m_k = -1; m_acc = 0; e_sample = 0; e_ready = 0; e_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs present this cycle.
  task automatic model_step();
    int alloc, visit;
    bit tick_b, any_exp;
    alloc = -1;
    for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) alloc = i;
    tick_b = beat && play_enable;
    visit = m_k;
    e_ready = 0;
    if (m_k >= 0) begin
      m_acc += contrib_model(m_k);
      if (m_k == NV - 1) begin
        e_sample = floor_div(m_acc, NV);
        e_ready = 1;
        m_k = -2;
      end else m_k++;
    end else if (m_k == -2) m_k = -1;
    else if (generate_next_sample) begin
      m_acc = 0; m_k = 0;
    end
    any_exp = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        if (i == visit && play_enable) m_phase[i] = (m_phase[i] + step_model(m_note[i])) % (1 << PW);
        if (tick_b) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin m_act[i] = 0; m_phase[i] = 0; any_exp = 1; end
        end
      end
    end
    if (load_new_note && alloc >= 0 && duration_to_load != 0) begin
      m_act[alloc] = 1; m_note[alloc] = note_to_load;
      m_rem[alloc] = duration_to_load; m_phase[alloc] = 0;
    end
    e_done = any_exp;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    if (reset) model_step();
    #2;
  endtask

  task automatic request_sample(output int lat);
    generate_next_sample = 1'b1;
    step_cycle();
    generate_next_sample = 1'b0;
    lat = 1;
    while (!new_sample_ready && lat < 12) begin
      step_cycle();
      lat++;
    end
    if (!new_sample_ready) check("sample_timeout", 0, 1);
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sample_out", int'(sample_out), e_sample);
      check("new_sample_ready", int'(new_sample_ready), e_ready);
      check("voices_active", int'(voices_active), active_vec());
      check("load_ready", int'(load_ready), (active_vec() != (1 << NV) - 1) ? 1 : 0);
      check("done_with_note", int'(done_with_note), e_done);
    end
  end

  initial begin
    int lat, cnt, pos;
    reset = 1'b0; play_enable = 1'b1; note_to_load = '0; duration_to_load = '0;
    load_new_note = 1'b0; wave_sel = 2'b00; beat = 1'b0; generate_next_sample = 1'b0;
    model_reset();
    chk_en = 1'b1;
    check("step_a4", step_model(49), 9612);
    step_cycle(); step_cycle();
    check("rst_load_ready", int'(load_ready), 1);
    check("rst_active", int'(voices_active), 0);
    reset = 1'b1;

    // Single note, two beats
    load_new_note = 1'b1; note_to_load = 6'd49; duration_to_load = 6'd2;
    step_cycle(); load_new_note = 1'b0;
    check("t2_active", int'(voices_active), 1);
    beat = 1'b1; step_cycle(); beat = 1'b0; step_cycle();
    beat = 1'b1; step_cycle(); beat = 1'b0;
    check("t2_done", int'(done_with_note), 1);
    check("t2_freed", int'(voices_active), 0);

    // Fill all voices, overflow load dropped, common expiry
    load_new_note = 1'b1; note_to_load = 6'd20; duration_to_load = 6'd3;
    repeat (4) step_cycle();
    check("t3_full", int'(voices_active), 15);
    check("t3_not_ready", int'(load_ready), 0);
    step_cycle(); load_new_note = 1'b0;
    check("t3_still_full", int'(voices_active), 15);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      beat = (i < 3); step_cycle(); cnt += done_with_note;
    end
    beat = 1'b0;
    check("t3_done_once", cnt, 1);
    check("t3_all_free", int'(voices_active), 0);

    // Square wave, latency and sign alternation
    load_new_note = 1'b1; note_to_load = 6'd49; duration_to_load = 6'd63;
    step_cycle(); load_new_note = 1'b0;
    request_sample(lat);
    check("t4_latency", lat, 5);
    check("t4_first", int'(sample_out), 8191);
    pos = 0;
    for (int j = 1; j <= 55; j++) begin
      step_cycle();
      request_sample(lat);
      if (sample_out > 0) pos++;
    end
    check("t4_positive_run", pos, 54);
    check("t4_flip", int'(sample_out), -8192);

    // Pause: second voice, beats ignored, silent mix
    step_cycle();
    play_enable = 1'b0;
    load_new_note = 1'b1; note_to_load = 6'd37; duration_to_load = 6'd2;
    step_cycle(); load_new_note = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1; step_cycle(); cnt += done_with_note; beat = 1'b0; step_cycle(); cnt += done_with_note;
    end
    request_sample(lat);
    check("t5_silent", int'(sample_out), 0);
    check("t5_active", int'(voices_active), 3);
    check("t5_no_done", cnt, 0);
    step_cycle();
    play_enable = 1'b1;
    beat = 1'b1; step_cycle(); beat = 1'b0; step_cycle();
    beat = 1'b1; step_cycle(); beat = 1'b0;
    check("t5_resume_done", int'(done_with_note), 1);
    check("t5_resume_active", int'(voices_active), 1);

    // Beat and load together: new voice keeps its full count
    load_new_note = 1'b1; beat = 1'b1; note_to_load = 6'd10; duration_to_load = 6'd1;
    step_cycle(); load_new_note = 1'b0; beat = 1'b0;
    check("t6_kept", int'(voices_active), 3);
    beat = 1'b1; step_cycle(); beat = 1'b0;
    check("t6_expire", int'(voices_active), 1);

    // Request during ACCUM ignored
    generate_next_sample = 1'b1; step_cycle(); generate_next_sample = 1'b0;
    step_cycle();
    generate_next_sample = 1'b1; step_cycle(); generate_next_sample = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step_cycle(); cnt += new_sample_ready; end
    check("t6_one_ready", cnt, 1);

    // Reset mid-ACCUM
    generate_next_sample = 1'b1; step_cycle(); generate_next_sample = 1'b0;
    step_cycle();
    reset = 1'b0; model_reset();
    #1;
    check("t6_rst_active", int'(voices_active), 0);
    check("t6_rst_sample", int'(sample_out), 0);
    check("t6_rst_ready", int'(load_ready), 1);
    step_cycle(); step_cycle();
    reset = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      play_enable = ($urandom_range(0, 9) != 0);
      load_new_note = ($urandom_range(0, 3) == 0);
      note_to_load = 6'($urandom_range(0, 63));
      duration_to_load = 6'($urandom_range(0, 7));
      beat = ($urandom_range(0, 7) == 0);
      generate_next_sample = ($urandom_range(0, 3) == 0);
      wave_sel = 2'($urandom_range(0, 3));
      step_cycle();
    end
    load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
    step_cycle(); step_cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
